mem_issue_queue: RTL
====================

Name: mem_issue_queue

Overview:
In-order issue queue for memory ops that feeds the AGU.
- Accepts one load/store per cycle from dispatch and holds its base-register operand (value or pending physical tag) plus Imm and ROB tag.
- Captures the base value from CDB wakeups.
- Issues the head entry to the AGU once its base is ready; honours freeze_back and flush.

Parameters:
DEPTH, 4, number of queue entries (power of 2, >=2)
DATA_W, 16, operand/address width
ROB_W, 5, ROB tag width
PREG_W, 5, physical register tag width
IMM_W, 5, memory-offset immediate width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  pipeline flush; empties queue
freeze_back  input  1  back-end stall; AGU holding, no issue pop
valid_dispatch  input  1  dispatch presents a memory op
ready_dispatch  output  1  queue can accept (count < DEPTH)
Imm_dispatch  input  IMM_W  offset immediate
tag_ROB_dispatch  input  ROB_W  ROB tag of op
tag_A_dispatch  input  PREG_W  physical tag of base register
ready_A_dispatch  input  1  base value already available
busA_dispatch  input  DATA_W  base value (valid when ready_A_dispatch)
valid_cdb  input  1  CDB broadcast valid
tag_cdb  input  PREG_W  CDB physical tag
data_cdb  input  DATA_W  CDB result
valid_agu  output  1  head issuing to AGU
busA_agu  output  DATA_W  head base value
Imm  output  IMM_W  head immediate
tag_ROB_agu  output  ROB_W  head ROB tag
count_mem  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Single clock clk. Synchronous active-high rst clears all state:
  - head, tail and count are 0; all entry valid/ready bits are 0.
  - All outputs read 0: valid_agu=0, busA_agu=0, Imm=0, tag_ROB_agu=0, count_mem=0. ready_dispatch=1.
- Storage: circular buffer; head/tail pointers are $clog2(DEPTH) bits and wrap naturally; count tracked separately.
- Each entry holds valid, rdyA, tagA, busA, Imm, tag_ROB.
- ready_dispatch = (count < DEPTH), from registered count only. A full queue refuses dispatch even if a pop occurs the same cycle.
- Dispatch (valid_dispatch & ready_dispatch): write entry at tail, tail+1.
  - rdyA = ready_A_dispatch | (valid_cdb & tag_cdb==tag_A_dispatch).
  - busA = busA_dispatch if ready_A_dispatch, else data_cdb if the CDB matches, else don't-care.
- Wakeup: every valid entry with !rdyA and tagA==tag_cdb while valid_cdb sets rdyA=1 and busA=data_cdb at the clock edge.
- Issue outputs are combinational from registered state only:
  - valid_agu = head.valid & head.rdyA.
  - busA_agu, Imm, tag_ROB_agu = head fields; they read 0 when the head is invalid.
  - Wakeup-to-issue latency is 1 cycle.
- Pop: at the edge when valid_agu & !freeze_back, clear head.valid, head+1. The AGU captures on that same edge.
- freeze_back=1: no pop; outputs held stable. Dispatch and wakeup continue normally.
- Strict in-order: a ready younger entry never bypasses an unready head.
- Count update: +1 dispatch, -1 pop, unchanged when both occur.
- flush: priority over dispatch, wakeup and pop. Next cycle the state equals the reset state. rst has priority over flush.
- No combinational path from any input to any output.

Decomposition:
- Package mem_iq_pkg: width constants (DATA_W, ROB_W, PREG_W, IMM_W) and typedef struct packed mem_iq_entry_t {valid, rdyA, tagA, busA, Imm, tag_ROB}.
- One sub-module: mem_iq_entry, a single entry register with write port, CDB tag compare/wakeup, and clear (flush/pop). Instantiated DEPTH times; pointer/count logic stays in the top.

Test Plan:
- Reset, then dispatch {ready_A=1, busA=0x0100, Imm=5'h1F, tag_ROB=3} -> next cycle valid_agu=1, busA_agu=0x0100, Imm=5'h1F, tag_ROB_agu=3; following cycle count_mem=0, valid_agu=0.
- Dispatch {ready_A=0, tag_A=7, tag_ROB=9}; two cycles later CDB {tag=7, data=0x1234} -> valid_agu stays 0 until the cycle after the CDB, then valid_agu=1, busA_agu=0x1234, tag_ROB_agu=9.
- Dispatch unready A (tag 4), then ready B -> valid_agu=0 while A is waiting; CDB tag 4 issues A, then B next cycle; order is A then B.
- Dispatch 4 entries -> ready_dispatch=0, count_mem=4; a 5th dispatch is ignored. Hold freeze_back=1 for 3 cycles with the head ready -> valid_agu=1 and outputs constant, count_mem=4; release -> one pop per cycle.
- Same-cycle dispatch {ready_A=0, tag_A=12} with CDB {tag=12, data=0xBEEF} -> entry issues next cycle with busA_agu=0xBEEF.
- With 3 entries queued, assert flush together with valid_dispatch and a matching CDB -> next cycle count_mem=0, valid_agu=0, ready_dispatch=1. Repeat the setup with rst instead -> same result.

Source files
------------

// File: rtl/mem_iq_pkg.sv
// Shared widths and the queue entry layout for the memory issue queue.
package mem_iq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned PREG_W = 5;
    localparam int unsigned IMM_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              rdyA;
        logic [PREG_W-1:0] tagA;
        logic [DATA_W-1:0] busA;
        logic [IMM_W-1:0]  Imm;
        logic [ROB_W-1:0]  tag_ROB;
    } mem_iq_entry_t;

endpackage

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: write port, CDB wakeup of the base operand, pop/flush clear.
module mem_iq_entry
    import mem_iq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              pop_i,
    input  logic              wr_en_i,
    input  mem_iq_entry_t     wr_entry_i,
    input  logic              valid_cdb_i,
    input  logic [PREG_W-1:0] tag_cdb_i,
    input  logic [DATA_W-1:0] data_cdb_i,
    output logic              valid_o,
    output logic              rdy_o,
    output logic [DATA_W-1:0] busA_o,
    output logic [IMM_W-1:0]  imm_o,
    output logic [ROB_W-1:0]  tag_rob_o
);

    mem_iq_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (entry_q.valid && !entry_q.rdyA && valid_cdb_i && (entry_q.tagA == tag_cdb_i)) begin
            entry_d.rdyA = 1'b1;
            entry_d.busA = data_cdb_i;
        end
        if (pop_i) begin
            entry_d.valid = 1'b0;
            entry_d.rdyA  = 1'b0;
        end
        // A slot is only written when it is free, so write wins outright.
        if (wr_en_i) begin
            entry_d = wr_entry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_o   = entry_q.valid;
    assign rdy_o     = entry_q.rdyA;
    assign busA_o    = entry_q.busA;
    assign imm_o     = entry_q.Imm;
    assign tag_rob_o = entry_q.tag_ROB;

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory-op issue queue feeding the AGU; head issues once its base operand is ready.
module mem_issue_queue
    import mem_iq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze_back,
    input  logic                       valid_dispatch,
    output logic                       ready_dispatch,
    input  logic [IMM_W-1:0]           Imm_dispatch,
    input  logic [ROB_W-1:0]           tag_ROB_dispatch,
    input  logic [PREG_W-1:0]          tag_A_dispatch,
    input  logic                       ready_A_dispatch,
    input  logic [DATA_W-1:0]          busA_dispatch,
    input  logic                       valid_cdb,
    input  logic [PREG_W-1:0]          tag_cdb,
    input  logic [DATA_W-1:0]          data_cdb,
    output logic                       valid_agu,
    output logic [DATA_W-1:0]          busA_agu,
    output logic [IMM_W-1:0]           Imm,
    output logic [ROB_W-1:0]           tag_ROB_agu,
    output logic [$clog2(DEPTH):0]     count_mem
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              ent_valid [DEPTH];
    logic              ent_rdy   [DEPTH];
    logic [DATA_W-1:0] ent_busA  [DEPTH];
    logic [IMM_W-1:0]  ent_imm   [DEPTH];
    logic [ROB_W-1:0]  ent_rob   [DEPTH];

    logic          dispatch, pop, head_valid;
    mem_iq_entry_t disp_entry;

    assign ready_dispatch = (count_q < CNT_W'(DEPTH));
    assign dispatch       = valid_dispatch && ready_dispatch;
    assign pop            = valid_agu && !freeze_back;

    always_comb begin
        disp_entry         = '0;
        disp_entry.valid   = 1'b1;
        disp_entry.rdyA    = ready_A_dispatch || (valid_cdb && (tag_cdb == tag_A_dispatch));
        disp_entry.tagA    = tag_A_dispatch;
        disp_entry.busA    = ready_A_dispatch ? busA_dispatch : data_cdb;
        disp_entry.Imm     = Imm_dispatch;
        disp_entry.tag_ROB = tag_ROB_dispatch;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        mem_iq_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush),
            .pop_i       (pop && (head_q == PTR_W'(i))),
            .wr_en_i     (dispatch && (tail_q == PTR_W'(i))),
            .wr_entry_i  (disp_entry),
            .valid_cdb_i (valid_cdb),
            .tag_cdb_i   (tag_cdb),
            .data_cdb_i  (data_cdb),
            .valid_o     (ent_valid[i]),
            .rdy_o       (ent_rdy[i]),
            .busA_o      (ent_busA[i]),
            .imm_o       (ent_imm[i]),
            .tag_rob_o   (ent_rob[i])
        );
    end

    assign head_valid  = ent_valid[head_q];
    assign valid_agu   = head_valid && ent_rdy[head_q];
    assign busA_agu    = head_valid ? ent_busA[head_q] : '0;
    assign Imm         = head_valid ? ent_imm[head_q] : '0;
    assign tag_ROB_agu = head_valid ? ent_rob[head_q] : '0;
    assign count_mem   = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (dispatch) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (dispatch && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!dispatch && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
